// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//
// Single-port controller for a 512K x 16 asynchronous SRAM. Takes one read or
// write request at a time over a valid/ready handshake and sequences the
// active-low SRAM strobes. Read strobe width and write pulse width are set by
// RD_CYCLES and WR_CYCLES (1..15 each).
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   req_valid  request present
//   req_ready  controller can accept a request this cycle (combinational)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   done       one-cycle pulse when a request completes
//   rsp_rdata  data of the most recent completed read
//   ADR        SRAM address
//   dat_out    SRAM write data, to the DAT tristate
//   dat_oe     1 = drive DAT with dat_out
//   dat_in     DAT pin value
//   RAMOE      SRAM output enable, active low
//   RAMWE      SRAM write enable, active low
//   RAMCS      SRAM chip select, active low
//
// State      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | strobes high, DAT released, ready for a request
// RD_WAIT    | CS/OE low for RD_CYCLES cycles, data sampled on the last edge
// WR_SETUP   | CS low, DAT driven, WE still high (address/data setup)
// WR_PULSE   | WE low for WR_CYCLES cycles
// WR_HOLD    | WE high again, CS/address/data held one more cycle
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [18:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        done,
    output logic [15:0] rsp_rdata,
    output logic [18:0] ADR,
    output logic [15:0] dat_out,
    output logic        dat_oe,
    input  logic [15:0] dat_in,
    output logic        RAMOE,
    output logic        RAMWE,
    output logic        RAMCS
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    // Down-counter load values: the counter runs LOAD..0, so a load of N-1
    // keeps the state for N cycles.
    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_done;
    logic [15:0] r_rsp_rdata;
    logic [18:0] r_adr;
    logic [15:0] r_dat_out;
    logic        r_dat_oe;
    logic        r_ramoe;
    logic        r_ramwe;
    logic        r_ramcs;

    logic        w_accept;
    logic        w_capture;
    logic        w_done_nxt;
    logic        w_dat_oe_nxt;
    logic        w_ramoe_nxt;
    logic        w_ramwe_nxt;
    logic        w_ramcs_nxt;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_we) begin
                        w_state_nxt = WR_SETUP;
                    end else begin
                        w_state_nxt = RD_WAIT;
                        w_cnt_nxt   = RD_LOAD;
                    end
                end
            end
            RD_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            WR_SETUP: begin
                w_state_nxt = WR_PULSE;
                w_cnt_nxt   = WR_LOAD;
            end
            WR_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            WR_HOLD: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Pin strobes are registered, so they are decoded from the state the
        // FSM is about to enter; this keeps them aligned with r_state.
        w_ramcs_nxt  = (w_state_nxt == IDLE);
        w_ramoe_nxt  = (w_state_nxt != RD_WAIT);
        w_ramwe_nxt  = (w_state_nxt != WR_PULSE);
        w_dat_oe_nxt = (w_state_nxt == WR_SETUP) || (w_state_nxt == WR_PULSE) ||
                       (w_state_nxt == WR_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_done      <= 1'b0;
            r_rsp_rdata <= 16'h0000;
            r_adr       <= 19'h00000;
            r_dat_out   <= 16'h0000;
            r_dat_oe    <= 1'b0;
            r_ramoe     <= 1'b1;
            r_ramwe     <= 1'b1;
            r_ramcs     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_dat_oe <= w_dat_oe_nxt;
            r_ramoe  <= w_ramoe_nxt;
            r_ramwe  <= w_ramwe_nxt;
            r_ramcs  <= w_ramcs_nxt;
            if (w_accept) begin
                r_adr <= req_addr;
                if (req_we) begin
                    r_dat_out <= req_wdata;
                end
            end
            if (w_capture) begin
                r_rsp_rdata <= dat_in;
            end
        end
    end

    assign done      = r_done;
    assign rsp_rdata = r_rsp_rdata;
    assign ADR       = r_adr;
    assign dat_out   = r_dat_out;
    assign dat_oe    = r_dat_oe;
    assign RAMOE     = r_ramoe;
    assign RAMWE     = r_ramwe;
    assign RAMCS     = r_ramcs;

endmodule

// File: tb/tb_sram_ctrl.sv
// Two controllers side by side: lane 0 with default widths (RD=2, WR=2) and
// lane 1 with RD=1, WR=5. Each lane has its own SRAM array. A transaction-level
// model (cycles since acceptance, shadow memory) predicts every output.
module tb_sram_ctrl;
    localparam int NL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [NL];
    logic        req_valid [NL];
    logic        req_ready [NL];
    logic        req_we    [NL];
    logic [18:0] req_addr  [NL];
    logic [15:0] req_wdata [NL];
    logic        done      [NL];
    logic [15:0] rsp_rdata [NL];
    logic [18:0] adr       [NL];
    logic [15:0] dat_out   [NL];
    logic        dat_oe    [NL];
    logic [15:0] dat_in    [NL];
    logic        ramoe     [NL];
    logic        ramwe     [NL];
    logic        ramcs     [NL];

    logic [15:0] mem [NL][524288];

    sram_ctrl #(.RD_CYCLES(2), .WR_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .done(done[0]), .rsp_rdata(rsp_rdata[0]), .ADR(adr[0]), .dat_out(dat_out[0]),
        .dat_oe(dat_oe[0]), .dat_in(dat_in[0]), .RAMOE(ramoe[0]), .RAMWE(ramwe[0]),
        .RAMCS(ramcs[0])
    );

    sram_ctrl #(.RD_CYCLES(1), .WR_CYCLES(5)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .done(done[1]), .rsp_rdata(rsp_rdata[1]), .ADR(adr[1]), .dat_out(dat_out[1]),
        .dat_oe(dat_oe[1]), .dat_in(dat_in[1]), .RAMOE(ramoe[1]), .RAMWE(ramwe[1]),
        .RAMCS(ramcs[1])
    );

    // SRAM only drives valid data while selected with OE low; otherwise junk.
    assign dat_in[0] = (!ramcs[0] && !ramoe[0]) ? mem[0][adr[0]] : 16'hDEAD;
    assign dat_in[1] = (!ramcs[1] && !ramoe[1]) ? mem[1][adr[1]] : 16'hDEAD;

    function automatic int rd_cyc(int l);
        return (l == 0) ? 2 : 1;
    endfunction

    function automatic int wr_cyc(int l);
        return (l == 0) ? 2 : 5;
    endfunction

    // ---------------- behavioural model ----------------
    logic [15:0] ref_mem [int];
    bit          m_busy  [NL];
    bit          m_we    [NL];
    int          m_k     [NL];
    logic [18:0] m_adr   [NL];
    logic [15:0] m_dout  [NL];
    logic [15:0] m_rsp   [NL];
    logic [15:0] m_rdval [NL];
    bit          m_done  [NL];
    int          cyc;
    int          n_chk;
    int          n_pass;
    logic [18:0] pool    [8];

    function automatic int mkey(int l, logic [18:0] a);
        return l * 524288 + int'(a);
    endfunction

    function automatic logic [15:0] ref_rd(int l, logic [18:0] a);
        if (ref_mem.exists(mkey(l, a))) return ref_mem[mkey(l, a)];
        return 16'h0000;
    endfunction

    task automatic chk(string name, int l, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s lane%0d cyc %0d: got 0x%0h expected 0x%0h", name, l, cyc, act, exp);
    endtask

    task automatic model_edge();
        cyc++;
        for (int l = 0; l < NL; l++) begin
            if (rst[l]) begin
                m_busy[l] = 1'b0;
                m_k[l]    = 0;
                m_adr[l]  = '0;
                m_dout[l] = '0;
                m_rsp[l]  = '0;
                m_done[l] = 1'b0;
            end else begin
                m_done[l] = 1'b0;
                if (m_busy[l]) begin
                    m_k[l]++;
                    if (!m_we[l] && m_k[l] == rd_cyc(l) + 1) begin
                        m_busy[l] = 1'b0;
                        m_done[l] = 1'b1;
                        m_rsp[l]  = m_rdval[l];
                    end else if (m_we[l] && m_k[l] == wr_cyc(l) + 3) begin
                        m_busy[l] = 1'b0;
                        m_done[l] = 1'b1;
                    end
                end else if (req_valid[l]) begin
                    m_busy[l] = 1'b1;
                    m_k[l]    = 1;
                    m_we[l]   = req_we[l];
                    m_adr[l]  = req_addr[l];
                    if (req_we[l]) begin
                        m_dout[l] = req_wdata[l];
                        ref_mem[mkey(l, req_addr[l])] = req_wdata[l];
                    end else begin
                        m_rdval[l] = ref_rd(l, req_addr[l]);
                    end
                end
            end
        end
    endtask

    task automatic compare();
        for (int l = 0; l < NL; l++) begin
            bit e_rd;
            bit e_wr;
            bit e_pulse;
            e_rd    = m_busy[l] && !m_we[l];
            e_wr    = m_busy[l] && m_we[l];
            e_pulse = e_wr && (m_k[l] >= 2) && (m_k[l] <= wr_cyc(l) + 1);
            chk("ramcs",     l, 32'(ramcs[l]),     32'(!m_busy[l]));
            chk("ramoe",     l, 32'(ramoe[l]),     32'(!e_rd));
            chk("ramwe",     l, 32'(ramwe[l]),     32'(!e_pulse));
            chk("dat_oe",    l, 32'(dat_oe[l]),    32'(e_wr));
            chk("adr",       l, 32'(adr[l]),       32'(m_adr[l]));
            chk("done",      l, 32'(done[l]),      32'(m_done[l]));
            chk("rsp_rdata", l, 32'(rsp_rdata[l]), 32'(m_rsp[l]));
            chk("req_ready", l, 32'(req_ready[l]), 32'(!m_busy[l] && !rst[l]));
            chk("oe_we_excl", l, 32'(ramoe[l] | ramwe[l]), 32'(1));
            chk("oe_doe_excl", l, 32'(!ramoe[l] && dat_oe[l]), 32'(0));
            if (e_wr) chk("dat_out", l, 32'(dat_out[l]), 32'(m_dout[l]));
        end
    endtask

    task automatic sram_write();
        for (int l = 0; l < NL; l++) begin
            if (!ramcs[l] && !ramwe[l]) mem[l][adr[l]] = dat_out[l];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        sram_write();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs(int l);
        req_valid[l] = 1'b0;
        req_we[l]    = 1'b0;
        req_addr[l]  = '0;
        req_wdata[l] = '0;
    endtask

    task automatic present(int l, bit we, logic [18:0] a, logic [15:0] d);
        req_valid[l] = 1'b1;
        req_we[l]    = we;
        req_addr[l]  = a;
        req_wdata[l] = d;
    endtask

    task automatic wait_idle(int l, int budget);
        int n;
        n = 0;
        while (m_busy[l] && n < budget) begin
            tick();
            n++;
        end
        if (m_busy[l]) begin
            n_chk++;
            $display("FAIL wait_idle lane%0d: still busy after %0d cycles, required idle", l, budget);
        end
    endtask

    task automatic random_phase(int l, int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (!m_busy[l] && $urandom_range(0, 3) != 0) begin
                present(l, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom));
            end else if (m_busy[l]) begin
                req_valid[l] = 1'($urandom_range(0, 1));
                req_we[l]    = 1'($urandom_range(0, 1));
                req_addr[l]  = 19'($urandom);
                req_wdata[l] = 16'($urandom);
            end else begin
                idle_inputs(l);
            end
            tick();
        end
        idle_inputs(l);
        wait_idle(l, 20);
    endtask

    initial begin
        int lows;
        logic [15:0] v;
        cyc    = 0;
        n_chk  = 0;
        n_pass = 0;
        pool[0] = 19'h00000; pool[1] = 19'h00001; pool[2] = 19'h00010; pool[3] = 19'h00020;
        pool[4] = 19'h7FFFF; pool[5] = 19'h40000; pool[6] = 19'h12345; pool[7] = 19'h2AAAA;
        for (int l = 0; l < NL; l++) begin
            rst[l] = 1'b1;
            idle_inputs(l);
            m_busy[l] = 1'b0;
            m_k[l]    = 0;
            for (int i = 0; i < 8; i++) begin
                if (pool[i] == 19'h7FFFF) v = 16'hFFFF;
                else if (pool[i] == 19'h00000) v = 16'h0001;
                else v = 16'($urandom);
                mem[l][pool[i]] = v;
                ref_mem[mkey(l, pool[i])] = v;
            end
        end

        repeat (3) tick();
        chk("rst_ramcs", 0, 32'(ramcs[0]), 32'(1));
        chk("rst_ready", 0, 32'(req_ready[0]), 32'(0));
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();
        chk("post_rst_ready", 0, 32'(req_ready[0]), 32'(1));
        chk("post_rst_ready", 1, 32'(req_ready[1]), 32'(1));

        // lane 0: single write with literal timing
        present(0, 1'b1, 19'h1A5A5, 16'hBEEF);
        tick();
        idle_inputs(0);
        chk("w1_adr_c1", 0, 32'(adr[0]), 32'h1A5A5);
        chk("w1_doe_c1", 0, 32'(dat_oe[0]), 32'(1));
        chk("w1_we_c1", 0, 32'(ramwe[0]), 32'(1));
        tick();
        chk("w1_we_c2", 0, 32'(ramwe[0]), 32'(0));
        tick();
        chk("w1_we_c3", 0, 32'(ramwe[0]), 32'(0));
        chk("w1_dout_c3", 0, 32'(dat_out[0]), 32'hBEEF);
        tick();
        chk("w1_we_c4", 0, 32'(ramwe[0]), 32'(1));
        chk("w1_doe_c4", 0, 32'(dat_oe[0]), 32'(1));
        chk("w1_done_c4", 0, 32'(done[0]), 32'(0));
        tick();
        chk("w1_done_c5", 0, 32'(done[0]), 32'(1));
        chk("w1_doe_c5", 0, 32'(dat_oe[0]), 32'(0));
        chk("w1_adr_c5", 0, 32'(adr[0]), 32'h1A5A5);

        // lane 0: write then read back
        present(0, 1'b1, 19'h00010, 16'h1234);
        tick();
        idle_inputs(0);
        wait_idle(0, 20);
        present(0, 1'b0, 19'h00010, 16'h0000);
        tick();
        idle_inputs(0);
        tick();
        chk("wr_rd_done_c2", 0, 32'(done[0]), 32'(0));
        tick();
        chk("wr_rd_done_c3", 0, 32'(done[0]), 32'(1));
        chk("wr_rd_data", 0, 32'(rsp_rdata[0]), 32'h1234);

        // lane 0: back-to-back reads, valid held high
        present(0, 1'b0, 19'h7FFFF, 16'h0000);
        tick();
        tick();
        tick();
        chk("b2b_done1", 0, 32'(done[0]), 32'(1));
        chk("b2b_data1", 0, 32'(rsp_rdata[0]), 32'hFFFF);
        chk("b2b_ready1", 0, 32'(req_ready[0]), 32'(1));
        req_addr[0] = 19'h00000;
        tick();
        chk("b2b_oe_c1", 0, 32'(ramoe[0]), 32'(0));
        chk("b2b_adr_c1", 0, 32'(adr[0]), 32'h00000);
        tick();
        idle_inputs(0);
        tick();
        chk("b2b_done2", 0, 32'(done[0]), 32'(1));
        chk("b2b_data2", 0, 32'(rsp_rdata[0]), 32'h0001);

        // lane 0: reset during the write pulse
        present(0, 1'b1, 19'h55555, 16'hCAFE);
        tick();
        idle_inputs(0);
        tick();
        chk("rw_pulse", 0, 32'(ramwe[0]), 32'(0));
        rst[0] = 1'b1;
        tick();
        chk("rw_ramwe", 0, 32'(ramwe[0]), 32'(1));
        chk("rw_ramcs", 0, 32'(ramcs[0]), 32'(1));
        chk("rw_ramoe", 0, 32'(ramoe[0]), 32'(1));
        chk("rw_dat_oe", 0, 32'(dat_oe[0]), 32'(0));
        chk("rw_adr", 0, 32'(adr[0]), 32'(0));
        chk("rw_dat_out", 0, 32'(dat_out[0]), 32'(0));
        chk("rw_rsp", 0, 32'(rsp_rdata[0]), 32'(0));
        chk("rw_done", 0, 32'(done[0]), 32'(0));
        tick();
        tick();
        rst[0] = 1'b0;
        tick();
        chk("rw_ready_after", 0, 32'(req_ready[0]), 32'(1));
        chk("rw_no_done", 0, 32'(done[0]), 32'(0));

        // lane 1: RD_CYCLES=1, WR_CYCLES=5
        present(1, 1'b0, 19'h7FFFF, 16'h0000);
        tick();
        idle_inputs(1);
        chk("l1_rd_oe_c1", 1, 32'(ramoe[1]), 32'(0));
        tick();
        chk("l1_rd_done_c2", 1, 32'(done[1]), 32'(1));
        chk("l1_rd_data", 1, 32'(rsp_rdata[1]), 32'hFFFF);
        present(1, 1'b1, 19'h00020, 16'hA55A);
        tick();
        idle_inputs(1);
        lows = 0;
        for (int i = 1; i < 8; i++) begin
            if (!ramwe[1]) lows++;
            chk("l1_wr_nodone", 1, 32'(done[1]), 32'(0));
            tick();
        end
        chk("l1_wr_done_c8", 1, 32'(done[1]), 32'(1));
        chk("l1_we_low_cycles", 1, 32'(lows), 32'(5));
        chk("l1_rsp_kept", 1, 32'(rsp_rdata[1]), 32'hFFFF);
        present(1, 1'b0, 19'h00020, 16'h0000);
        tick();
        idle_inputs(1);
        tick();
        chk("l1_rd2_done", 1, 32'(done[1]), 32'(1));
        chk("l1_rd2_data", 1, 32'(rsp_rdata[1]), 32'hA55A);

        // randomized traffic on both lanes, one after the other
        random_phase(0, 1500);
        random_phase(1, 1500);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
